agc_level_controller: RTL
=========================

Name: agc_level_controller

Overview:
Closed-loop AGC sequencer that drives the 6-bit gain binary-search block.
- Measures ADC sample amplitude over fixed windows.
- Compares each window's peak against high and low thresholds.
- Issues single-cycle adjust/up_dn commands to the gain search block until it reports done or the level falls inside the target band.
- Sits between the ADC sample stream and the gain search block in the RX front end.

Parameters:
DATA_W, 8, width of signed two's-complement ADC samples
WIN_LEN, 64, accepted samples per measurement window (power of 2, ≥2)
SETTLE_CYC, 16, clk cycles waited after any gain change before measuring (≥1)
HI_TH, 96, peak above this value means gain is too high
LO_TH, 48, peak below this value means gain is too low (LO_TH < HI_TH)
MAX_ADJ, 7, adjust commands allowed before forced lock

Ports:
clk  in  1  system clock
RESET  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse that begins acquisition from IDLE
sample_valid  in  1  sample qualifier
sample  in  DATA_W  signed ADC sample
search_done  in  1  done flag from the gain search block
adjust  out  1  one-cycle gain-change command
up_dn  out  1  1 = raise gain, 0 = lower gain; meaningful only while adjust=1, 0 otherwise
busy  out  1  high in every state except IDLE and LOCKED
locked  out  1  sticky, high in LOCKED
timeout  out  1  sticky, set when lock was forced by MAX_ADJ
peak  out  DATA_W-1  peak magnitude of the most recently completed window

Behaviour:
- Reset (async, RESET=1): state=IDLE; adjust, up_dn, busy, locked, timeout, peak, all counters = 0.
- Magnitude:
  - mag = |sample| as DATA_W-1 unsigned bits.
  - The most negative code saturates to 2^(DATA_W-1)-1.
  - The running max updates only on sample_valid=1.
- States:
  - IDLE: start=1 -> SETTLE. All other inputs are ignored.
  - SETTLE:
    - Count SETTLE_CYC cycles.
    - At the end of the count: search_done=1 -> LOCKED; otherwise -> MEASURE, clearing the running max and window counter.
  - MEASURE:
    - Accept samples while sample_valid=1; sample_valid=0 stalls the window count.
    - After the WIN_LEN-th accepted sample (this sample included in the max) -> DECIDE.
  - DECIDE (one cycle):
    - Register peak.
    - peak>HI_TH -> ADJUST with up_dn=0.
    - peak<LO_TH -> ADJUST with up_dn=1.
    - Otherwise -> LOCKED.
    - If adj_cnt==MAX_ADJ and an adjust would be needed -> LOCKED with timeout=1.
  - ADJUST (one cycle): adjust=1 with up_dn held; adj_cnt++; -> SETTLE.
  - LOCKED: locked=1, busy=0. Exit only via RESET; start is ignored.
- adjust is registered: it is high exactly in the second cycle after the cycle in which the final window sample is accepted.
- Gain requests are never back-to-back: at least SETTLE_CYC + WIN_LEN + 1 cycles separate two adjust pulses.
- Boundaries:
  - peak == HI_TH or peak == LO_TH counts as in-band.
  - start while busy: ignored.
  - search_done rising mid-MEASURE: no effect until the next SETTLE exit.
  - RESET mid-operation: immediate return to the reset values; adjust must not glitch high.
- adj_cnt is 3 bits minimum, sized as clog2(MAX_ADJ+1).

Optional Feature:
AGC_CLIP_DETECT_EN:
- Defined:
  - Adds parameter CLIP_LIM (default 4).
  - Counts samples in the window with mag == 2^(DATA_W-1)-1.
  - If the count ≥ CLIP_LIM, DECIDE treats the window as too-high (up_dn=0) regardless of peak.
- Undefined: no clip counter; the decision uses peak only.

Decomposition:
- Package agc_pkg:
  - FSM state enum (IDLE, SETTLE, MEASURE, DECIDE, ADJUST, LOCKED).
  - Default threshold/window constants.
  - Gain width constant (6).
- Sub-module agc_peak_detector:
  - Contains the abs/saturate logic, running max, window counter and optional clip counter.
  - Outputs win_done pulse, peak and clip flag.

Test Plan:
- Reset, then start; feed 64 valid samples alternating +120/−120 after 16 settle cycles -> peak=120, adjust=1 with up_dn=0 exactly two cycles after the last sample, busy=1.
- Feed windows of ±20 repeatedly with search_done=0 -> an adjust/up_dn=1 pulse per window; after 7 pulses the next out-of-band window gives locked=1, timeout=1, no 8th pulse.
- Window peak 70 (in band) -> no adjust, locked=1, timeout=0; later start pulses and samples have no effect.
- search_done=1 asserted during SETTLE after the 3rd adjust -> LOCKED at settle end with no further MEASURE window; sample −128 alone gives peak=127 (saturation check).
- sample_valid toggled every other cycle -> window completes after 64 valid samples (~128 cycles), not after 64 cycles; RESET pulsed mid-window -> all outputs 0 immediately and FSM back in IDLE.
- With AGC_CLIP_DETECT_EN defined: a window of 5 samples at 127 and the rest 0 (peak=127) gives up_dn=0; a window of 3 samples at 127 and the rest at 60 gives up_dn=0 (peak>HI_TH), while the same window with 127 replaced by 90 gives locked=1.

Source files
------------

// File: rtl/agc_pkg.sv
// agc_pkg: shared types and default constants for the AGC level controller.
//   agc_state_t   : sequencer states (IDLE, SETTLE, MEASURE, DECIDE, ADJUST, LOCKED)
//   AGC_*         : default sample width, window, settle, threshold and adjust limits
//   AGC_GAIN_W    : width of the gain word held by the gain search block
package agc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        ADJUST,
        LOCKED
    } agc_state_t;

    localparam int AGC_DATA_W     = 8;
    localparam int AGC_WIN_LEN    = 64;
    localparam int AGC_SETTLE_CYC = 16;
    localparam int AGC_HI_TH      = 96;
    localparam int AGC_LO_TH      = 48;
    localparam int AGC_MAX_ADJ    = 7;
    localparam int AGC_CLIP_LIM   = 4;
    localparam int AGC_GAIN_W     = 6;

endpackage

// File: rtl/agc_peak_detector.sv
// agc_peak_detector: per-window amplitude measurement.
//   clk, RESET    : clock, asynchronous active-high reset
//   clr           : restart the window (running max, sample count, clip count)
//   en            : measurement window open
//   sample_valid  : sample qualifier
//   sample        : signed ADC sample
//   win_done      : pulses in the cycle the WIN_LEN-th sample is accepted
//   peak          : running max of |sample| (saturated) over the window
//   clip          : (AGC_CLIP_DETECT_EN only) full-scale sample count >= CLIP_LIM
// Optional feature macro: AGC_CLIP_DETECT_EN
module agc_peak_detector
    import agc_pkg::*;
#(
    parameter int DATA_W  = AGC_DATA_W,
    parameter int WIN_LEN = AGC_WIN_LEN
`ifdef AGC_CLIP_DETECT_EN
    , parameter int CLIP_LIM = AGC_CLIP_LIM
`endif
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              clr,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              win_done,
    output logic [DATA_W-2:0] peak
`ifdef AGC_CLIP_DETECT_EN
    , output logic            clip
`endif
);

    localparam int MW = DATA_W - 1;
    localparam int CW = $clog2(WIN_LEN);
    localparam logic [MW-1:0] MAG_MAX = '1;

    logic [DATA_W-1:0] neg;
    logic [MW-1:0]     mag;
    logic [MW-1:0]     run_max;
    logic [CW-1:0]     win_cnt;
    logic              accept;

    assign neg = '0 - sample;

    // Only the most negative code negates to a value with the top bit set;
    // that single case saturates to full scale.
    always_comb begin
        mag = sample[MW-1:0];
        if (sample[DATA_W-1]) begin
            mag = neg[DATA_W-1] ? MAG_MAX : neg[MW-1:0];
        end
    end

    assign accept   = en && sample_valid;
    assign win_done = accept && (win_cnt == CW'(WIN_LEN - 1));
    assign peak     = run_max;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            win_cnt <= '0;
            run_max <= '0;
        end else if (clr) begin
            win_cnt <= '0;
            run_max <= '0;
        end else if (accept) begin
            win_cnt <= win_cnt + CW'(1);
            if (mag > run_max) begin
                run_max <= mag;
            end
        end
    end

`ifdef AGC_CLIP_DETECT_EN
    localparam int KW = $clog2(WIN_LEN + 1);
    logic [KW-1:0] clip_cnt;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            clip_cnt <= '0;
        end else if (clr) begin
            clip_cnt <= '0;
        end else if (accept && (mag == MAG_MAX)) begin
            clip_cnt <= clip_cnt + KW'(1);
        end
    end

    assign clip = (clip_cnt >= KW'(CLIP_LIM));
`endif

endmodule

// File: rtl/agc_level_controller.sv
// agc_level_controller: closed-loop AGC sequencer driving the gain search block.
//   clk, RESET    : clock, asynchronous active-high reset
//   start         : one-cycle pulse, begins acquisition from IDLE
//   sample_valid  : ADC sample qualifier
//   sample        : signed ADC sample
//   search_done   : done flag from the gain search block (sampled at settle end)
//   adjust        : one-cycle gain-change command
//   up_dn         : 1 = raise gain, 0 = lower gain (valid with adjust, else 0)
//   busy          : high outside IDLE and LOCKED
//   locked        : high in LOCKED (left only through RESET)
//   timeout       : sticky, lock forced after MAX_ADJ adjust commands
//   peak          : peak magnitude of the most recently completed window
// Optional feature macro: AGC_CLIP_DETECT_EN (clip-count based too-high decision)
module agc_level_controller
    import agc_pkg::*;
#(
    parameter int DATA_W     = AGC_DATA_W,
    parameter int WIN_LEN    = AGC_WIN_LEN,
    parameter int SETTLE_CYC = AGC_SETTLE_CYC,
    parameter int HI_TH      = AGC_HI_TH,
    parameter int LO_TH      = AGC_LO_TH,
    parameter int MAX_ADJ    = AGC_MAX_ADJ
`ifdef AGC_CLIP_DETECT_EN
    , parameter int CLIP_LIM = AGC_CLIP_LIM
`endif
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              search_done,
    output logic              adjust,
    output logic              up_dn,
    output logic              busy,
    output logic              locked,
    output logic              timeout,
    output logic [DATA_W-2:0] peak
);

    localparam int MW = DATA_W - 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int AW = ($clog2(MAX_ADJ + 1) < 3) ? 3 : $clog2(MAX_ADJ + 1);
    localparam logic [MW-1:0] HI_V = MW'(HI_TH);
    localparam logic [MW-1:0] LO_V = MW'(LO_TH);

    agc_state_t    state, state_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [AW-1:0] adj_cnt, adj_n;
    logic          adjust_q, adjust_n;
    logic          up_dn_q, up_dn_n;
    logic          timeout_q, timeout_n;
    logic [MW-1:0] peak_q, peak_n;

    logic          det_clr, det_en, win_done;
    logic [MW-1:0] run_max;
    logic          too_high, too_low;

`ifdef AGC_CLIP_DETECT_EN
    logic clip;
`endif

    agc_peak_detector #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN)
`ifdef AGC_CLIP_DETECT_EN
        , .CLIP_LIM(CLIP_LIM)
`endif
    ) u_det (
        .clk          (clk),
        .RESET        (RESET),
        .clr          (det_clr),
        .en           (det_en),
        .sample_valid (sample_valid),
        .sample       (sample),
        .win_done     (win_done),
        .peak         (run_max)
`ifdef AGC_CLIP_DETECT_EN
        , .clip       (clip)
`endif
    );

`ifdef AGC_CLIP_DETECT_EN
    assign too_high = (run_max > HI_V) || clip;
`else
    assign too_high = (run_max > HI_V);
`endif
    assign too_low = !too_high && (run_max < LO_V);

    always_comb begin
        state_n   = state;
        settle_n  = settle_cnt;
        adj_n     = adj_cnt;
        adjust_n  = 1'b0;
        up_dn_n   = 1'b0;
        timeout_n = timeout_q;
        peak_n    = peak_q;
        det_clr   = 1'b0;
        det_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = SETTLE;
                    settle_n = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    settle_n = '0;
                    if (search_done) begin
                        state_n = LOCKED;
                    end else begin
                        state_n = MEASURE;
                        det_clr = 1'b1;
                    end
                end else begin
                    settle_n = settle_cnt + SW'(1);
                end
            end
            MEASURE: begin
                det_en = 1'b1;
                if (win_done) begin
                    state_n = DECIDE;
                end
            end
            DECIDE: begin
                peak_n = run_max;
                if (too_high || too_low) begin
                    if (adj_cnt == AW'(MAX_ADJ)) begin
                        state_n   = LOCKED;
                        timeout_n = 1'b1;
                    end else begin
                        // adjust/up_dn are registered so they are high
                        // exactly for the ADJUST cycle.
                        state_n  = ADJUST;
                        adjust_n = 1'b1;
                        up_dn_n  = too_low;
                    end
                end else begin
                    state_n = LOCKED;
                end
            end
            ADJUST: begin
                adj_n    = adj_cnt + AW'(1);
                settle_n = '0;
                state_n  = SETTLE;
            end
            LOCKED: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            settle_cnt <= '0;
            adj_cnt    <= '0;
            adjust_q   <= 1'b0;
            up_dn_q    <= 1'b0;
            timeout_q  <= 1'b0;
            peak_q     <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            adj_cnt    <= adj_n;
            adjust_q   <= adjust_n;
            up_dn_q    <= up_dn_n;
            timeout_q  <= timeout_n;
            peak_q     <= peak_n;
        end
    end

    assign adjust  = adjust_q;
    assign up_dn   = up_dn_q;
    assign busy    = (state != IDLE) && (state != LOCKED);
    assign locked  = (state == LOCKED);
    assign timeout = timeout_q;
    assign peak    = peak_q;

endmodule
